// File: rtl/alu2_arbiter.sv
// Round-robin arbiter that shares one multi-cycle ALU2 between N_REQ issue requesters,
// with a single op in flight, a valid/ready result port, ALU2 clear handshaking and flush.
package core_config_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [3:0] {
    c_NONE = 4'd0, c_MUL, c_MULH, c_MULHSU, c_MULHU,
    c_DIV, c_DIVU, c_REM, c_REMU, c_SLL, c_SRL, c_SRA
  } alu_commands_t;
endpackage

module alu2_arbiter #(
  parameter int N_REQ      = 2,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid,
  output logic [N_REQ-1:0]                      req_ready,
  input  core_config_pkg::alu_commands_t [N_REQ-1:0] req_cmd,
  input  logic [N_REQ*XLEN-1:0]                 req_arg0,
  input  logic [N_REQ*XLEN-1:0]                 req_arg1,
  input  logic [N_REQ*REG_ADDR_W-1:0]           req_rd,
  input  logic                                  flush,
  output logic                                  resp_valid,
  input  logic                                  resp_ready,
  output logic [$clog2(N_REQ)-1:0]              resp_id,
  output logic [XLEN-1:0]                       resp_res,
  output logic [REG_ADDR_W-1:0]                 resp_rd,
  output logic                                  resp_error,
  output core_config_pkg::alu_commands_t        alu_cmd,
  output logic [XLEN-1:0]                       alu_arg0,
  output logic [XLEN-1:0]                       alu_arg1,
  output logic [REG_ADDR_W-1:0]                 alu_rd,
  input  logic                                  alu_busy,
  input  logic                                  alu_i_error,
  input  logic                                  alu_valid,
  input  logic [XLEN-1:0]                       alu_res,
  input  logic                                  alu_o_error,
  output logic                                  alu_clear
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;
  state_t state, state_nx;

  logic [N_REQ-1:0][XLEN-1:0]       arg0_v, arg1_v;
  logic [N_REQ-1:0][REG_ADDR_W-1:0] rd_v;
  logic [ID_W-1:0]                  rr_ptr, grant, rr_nx;
  logic [ID_W:0]                    idx;
  logic                             grant_vld, accept;
  core_config_pkg::alu_commands_t   cmd_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign arg0_v[i] = req_arg0[i*XLEN +: XLEN];
    assign arg1_v[i] = req_arg1[i*XLEN +: XLEN];
    assign rd_v[i]   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
  end

  // Scan downward so the last hit is the first valid index at or after rr_ptr.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (req_valid[idx[ID_W-1:0]]) begin
        grant     = idx[ID_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  assign rr_nx = (grant == ID_W'(N_REQ-1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    accept     = 1'b0;
    alu_cmd    = core_config_pkg::c_NONE;
    alu_clear  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: if (grant_vld && !alu_busy && !flush) begin
        accept           = 1'b1;
        req_ready[grant] = 1'b1;
        state_nx         = S_ISSUE;
      end
      S_ISSUE: begin
        alu_cmd = cmd_q;
        if (alu_i_error) state_nx = flush ? S_IDLE : S_RESP;
        else             state_nx = flush ? S_DRAIN : S_WAIT;
      end
      // A flush coinciding with alu_valid still drains: the clear happens from DRAIN.
      S_WAIT: begin
        if (flush)          state_nx = S_DRAIN;
        else if (alu_valid) state_nx = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (flush || resp_ready) begin
          alu_clear = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      S_DRAIN: if (alu_valid) begin
        alu_clear = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      cmd_q      <= core_config_pkg::c_NONE;
      alu_arg0   <= '0;
      alu_arg1   <= '0;
      alu_rd     <= '0;
      resp_id    <= '0;
      resp_rd    <= '0;
      resp_res   <= '0;
      resp_error <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr   <= rr_nx;
        cmd_q    <= req_cmd[grant];
        alu_arg0 <= arg0_v[grant];
        alu_arg1 <= arg1_v[grant];
        alu_rd   <= rd_v[grant];
        resp_id  <= grant;
        resp_rd  <= rd_v[grant];
      end
      if (state == S_ISSUE && alu_i_error && !flush) begin
        resp_res   <= '0;
        resp_error <= 1'b1;
      end else if (state == S_WAIT && alu_valid && !flush) begin
        resp_res   <= alu_res;
        resp_error <= alu_o_error;
      end
    end
  end
endmodule

// File: tb/tb_alu2_arbiter.sv
// Directed bench for alu2_arbiter with a small behavioural ALU2 model attached.
module tb_alu2_arbiter;
  import core_config_pkg::*;
  localparam int N = 2;
  localparam int XW = 32;
  localparam int RW = 5;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  alu_commands_t [N-1:0] req_cmd = '{default: c_NONE};
  logic [N*XW-1:0] req_arg0 = '0, req_arg1 = '0;
  logic [N*RW-1:0] req_rd = '0;
  logic flush = 1'b0, resp_valid, resp_ready = 1'b0, resp_error;
  logic [0:0] resp_id;
  logic [XW-1:0] resp_res, alu_arg0, alu_arg1, alu_res;
  logic [RW-1:0] resp_rd, alu_rd;
  alu_commands_t alu_cmd;
  logic alu_busy, alu_i_error, alu_valid, alu_o_error, alu_clear;

  int checks = 0, errors = 0;
  int clr_cnt = 0, rdy0_cnt = 0, busy_cnt = 0;

  always #5 clk = ~clk;

  alu2_arbiter #(.N_REQ(N), .XLEN(XW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_arg0(req_arg0), .req_arg1(req_arg1), .req_rd(req_rd), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_res(resp_res),
    .resp_rd(resp_rd), .resp_error(resp_error), .alu_cmd(alu_cmd), .alu_arg0(alu_arg0),
    .alu_arg1(alu_arg1), .alu_rd(alu_rd), .alu_busy(alu_busy), .alu_i_error(alu_i_error),
    .alu_valid(alu_valid), .alu_res(alu_res), .alu_o_error(alu_o_error), .alu_clear(alu_clear));

  // ALU2 model: captures on the edge ending the ISSUE cycle, holds result until clear.
  logic issue_q;
  int   cnt;
  function automatic logic known(alu_commands_t c);
    return (c != c_NONE) && (c <= c_SRA);
  endfunction
  function automatic logic [XW-1:0] model_res(alu_commands_t c, logic [XW-1:0] a, logic [XW-1:0] b);
    case (c)
      c_MUL:   return a * b;
      c_DIVU:  return (b == 0) ? '1 : a / b;
      c_DIV:   return (b == 0) ? '1 : XW'($signed(a) / $signed(b));
      default: return '0;
    endcase
  endfunction

  assign alu_i_error = issue_q && !known(alu_cmd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q <= 1'b0; alu_busy <= 1'b0; alu_valid <= 1'b0;
      alu_res <= '0; alu_o_error <= 1'b0; cnt <= 0;
    end else begin
      issue_q <= |req_ready;
      if (alu_clear) begin
        alu_busy <= 1'b0; alu_valid <= 1'b0;
      end else if (issue_q && known(alu_cmd)) begin
        alu_busy    <= 1'b1;
        cnt         <= (alu_cmd inside {c_DIV, c_DIVU, c_REM, c_REMU}) ? 6 : 2;
        alu_res     <= model_res(alu_cmd, alu_arg0, alu_arg1);
        alu_o_error <= (alu_cmd inside {c_DIV, c_DIVU, c_REM, c_REMU}) && (alu_arg1 == 0);
      end else if (alu_busy && !alu_valid) begin
        if (cnt == 0) alu_valid <= 1'b1;
        else          cnt <= cnt - 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alu_clear)    clr_cnt  <= clr_cnt + 1;
    if (req_ready[0]) rdy0_cnt <= rdy0_cnt + 1;
    if (alu_busy)     busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int i, input alu_commands_t c, input logic [XW-1:0] a,
                       input logic [XW-1:0] b, input logic [RW-1:0] rd);
    int n = 0;
    req_cmd[i] = c; req_arg0[i*XW +: XW] = a; req_arg1[i*XW +: XW] = b;
    req_rd[i*RW +: RW] = rd; req_valid[i] = 1'b1; #1;
    while (!req_ready[i] && n < 50) begin cyc(); n++; end
    chk("grant", 64'(req_ready[i]), 64'd1);
    cyc(); req_valid[i] = 1'b0; #1;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (!resp_valid && n < 50) begin cyc(); n++; end
    chk("resp_timeout", 64'(resp_valid), 64'd1);
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1; #1;
    chk(tag, 64'({alu_clear, req_ready}), 64'(3'b100));
    cyc(); resp_ready = 1'b0; #1;
    chk("clear_one_cycle", 64'(alu_clear), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0; #1;
  endtask

  int c0, r0, b0, n;
  logic [N-1:0] exp_g;

  initial begin
    do_reset();
    chk("rst_out", 64'({req_ready, resp_valid, resp_id, resp_error, alu_clear}), 64'd0);
    chk("rst_data", 64'({resp_res, resp_rd, alu_rd}), 64'd0);
    chk("rst_alu", 64'({alu_cmd, alu_arg0}), 64'd0);

    // single MUL on requester 0
    c0 = clr_cnt; r0 = rdy0_cnt;
    issue(0, c_MUL, 32'd7, 32'd6, 5'd5);
    chk("issue_cmd", 64'({alu_cmd, alu_arg0, alu_rd}), 64'({c_MUL, 32'd7, 5'd5}));
    cyc();
    chk("wait_cmd_none", 64'(alu_cmd), 64'(c_NONE));
    wait_resp();
    chk("mul_resp", 64'({resp_res, resp_rd, resp_id, resp_error}), 64'({32'd42, 5'd5, 1'b0, 1'b0}));
    handshake("mul_clear");
    chk("mul_pulses", 64'({rdy0_cnt - r0, clr_cnt - c0}), 64'({32'd1, 32'd1}));

    // round-robin with both requesters always valid
    do_reset();
    req_cmd = '{c_MUL, c_MUL};
    req_arg0 = {32'd4, 32'd2}; req_arg1 = {32'd5, 32'd3}; req_rd = {5'd11, 5'd10};
    req_valid = 2'b11; #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      while (!(|req_ready) && n < 50) begin cyc(); n++; end
      chk("rr_grant", 64'(req_ready), 64'(exp_g));
      cyc();
      wait_resp();
      chk("rr_resp", 64'({resp_id, resp_res}),
          (k % 2 == 0) ? 64'({1'b0, 32'd6}) : 64'({1'b1, 32'd20}));
      handshake("rr_clear");
    end
    req_valid = '0; #1;

    // DIVU by zero on requester 1
    issue(1, c_DIVU, 32'd100, 32'd0, 5'd9);
    wait_resp();
    chk("divz_resp", 64'({resp_error, resp_res, resp_id, resp_rd}),
        64'({1'b1, 32'hFFFF_FFFF, 1'b1, 5'd9}));
    handshake("divz_clear");

    // unknown command: error response two cycles after accept, ALU never busy
    b0 = busy_cnt;
    issue(0, c_NONE, 32'd3, 32'd4, 5'd2);
    chk("none_t1", 64'(resp_valid), 64'd0);
    cyc();
    chk("none_resp", 64'({resp_valid, resp_error, resp_res, resp_rd, resp_id}),
        64'({1'b1, 1'b1, 32'd0, 5'd2, 1'b0}));
    handshake("none_clear");
    chk("none_busy", 64'(busy_cnt - b0), 64'd0);

    // back-pressure for 10 cycles with another requester waiting
    issue(1, c_MUL, 32'd3, 32'd5, 5'd7);
    req_cmd[0] = c_MUL; req_arg0[XW-1:0] = 32'd1; req_arg1[XW-1:0] = 32'd1;
    req_rd[RW-1:0] = 5'd1; req_valid[0] = 1'b1;
    wait_resp();
    for (int k = 0; k < 10; k++) begin
      chk("stall", 64'({resp_valid, resp_res, resp_rd, resp_id, alu_clear, req_ready}),
          64'({1'b1, 32'd15, 5'd7, 1'b1, 1'b0, 2'b00}));
      cyc();
    end
    handshake("stall_clear");
    chk("next_accept", 64'(req_ready), 64'(2'b01));
    cyc(); req_valid[0] = 1'b0; #1;
    wait_resp();
    chk("after_stall", 64'({resp_id, resp_res}), 64'({1'b0, 32'd1}));
    handshake("after_stall_clear");

    // flush while DIV is in WAIT
    c0 = clr_cnt;
    issue(0, c_DIV, -32'sd20, 32'd3, 5'd4);
    cyc();
    flush = 1'b1; #1;
    chk("flush_no_clear", 64'(alu_clear), 64'd0);
    cyc(); flush = 1'b0; #1;
    n = 0;
    while (!alu_clear && n < 20) begin
      chk("drain_no_resp", 64'(resp_valid), 64'd0);
      cyc(); n++;
    end
    chk("drain_clear", 64'({alu_clear, alu_valid, resp_valid}), 64'(3'b110));
    cyc();
    chk("drain_pulses", 64'({clr_cnt - c0, 31'd0, alu_busy}), 64'({32'd1, 32'd0}));
    issue(1, c_MUL, 32'd2, 32'd3, 5'd8);
    wait_resp();
    chk("post_flush", 64'({resp_id, resp_res, resp_rd, resp_error}), 64'({1'b1, 32'd6, 5'd8, 1'b0}));
    handshake("post_flush_clear");

    // flush in RESP wins over resp_ready
    issue(0, c_MUL, 32'd9, 32'd9, 5'd3);
    wait_resp();
    chk("resp81", 64'(resp_res), 64'd81);
    flush = 1'b1; resp_ready = 1'b1; #1;
    chk("resp_flush_clear", 64'(alu_clear), 64'd1);
    cyc(); flush = 1'b0; resp_ready = 1'b0; #1;
    chk("resp_flush_drop", 64'({resp_valid, alu_clear}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end
endmodule
